regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised register file with an integrated write-pending scoreboard for the pipelined MIPS core. It provides NUM_RD combinational read ports, one write (writeback) port and one issue port that marks a destination register pending until its writeback arrives. Register 0 is hardwired to zero and is never pending. It sits between decode (reads, issue, hazard check) and writeback.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; **asynchronous, active-low**
- ra  in  NUM_RD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W]
- rd  out  NUM_RD*DATA_W  read data; port i at [i*DATA_W +: DATA_W]
- busy  out  NUM_RD  busy[i] = register ra[i] still awaiting writeback
- we  in  1  writeback enable
- wa  in  ADDR_W  writeback address
- wd  in  DATA_W  writeback data
- iss_valid  in  1  an instruction with destination iss_addr issues this cycle
- iss_addr  in  ADDR_W  destination register of issuing instruction
- iss_ready  out  1  iss_addr may be issued this cycle
- pend_cnt  out  ADDR_W+1  number of registers currently pending
- err  out  1  sticky protocol error flag

## Operation
- Storage: 2**ADDR_W - 1 registers of DATA_W bits (address 0 not stored) plus one pending bit per register.
- Reads: rd[i] = 0 when ra[i]==0, else stored value (see Configuration for same-cycle bypass).
- Writeback: on we with wa!=0, reg[wa] <= wd and pending[wa] <= 0 at the edge. we with wa==0: no effect.
- Issue: iss_ready = (iss_addr==0) | ~pending[iss_addr] | (we & wa==iss_addr). Accepted issue (iss_valid & iss_ready & iss_addr!=0) sets pending[iss_addr] <= 1.
- Issue and writeback to same register, same cycle: issue wins, pending stays 1; data is still written.
- iss_valid & ~iss_ready: issue ignored, pending unchanged, err <= 1 (sticky until reset).
- we to a non-pending nonzero register: legal (plain write), err unaffected.
- busy[i] = (ra[i]!=0) & pending[ra[i]], qualified per Configuration.
- pend_cnt: +1 on accepted issue to a non-pending register, -1 on writeback clearing a pending register with no same-cycle re-issue; net 0 when both hit the same register or cancel. Range 0..2**ADDR_W-1; never wraps.

## Timing
- Reset (rst_n low, asynchronous): all registers 0, all pending 0, pend_cnt 0, err 0. Outputs during/after reset: rd all 0, busy all 0, iss_ready 1, pend_cnt 0, err 0. Reset asserted mid-operation discards all state immediately, regardless of clk.
- Read latency: combinational, zero cycles; write visible to reads from the cycle after the edge (earlier with bypass).
- Scoreboard latency: pending set/cleared at the edge following the issue/writeback cycle; busy and iss_ready combinational from current pending bits plus same-cycle writeback.
- No handshake stalls inside the block; decode must hold the instruction while iss_ready or busy demands it.

## Configuration
- REGFILE_BYPASS_EN defined: write-through bypass. When we & wa!=0 & wa==ra[i], rd[i]=wd and busy[i]=0 in the same cycle.
- REGFILE_BYPASS_EN undefined: rd[i] returns pre-edge stored value; busy[i] reflects pending bit only (stays 1 during the writeback cycle). iss_ready same-cycle writeback term still applies in both builds.

## Test plan
- Reset then read: rst_n low 2 cycles, ra={5,0} -> rd={0,0}, busy=00, iss_ready=1, pend_cnt=0, err=0.
- Write/read and zero register: we, wa=7, wd=0xDEADBEEF; next cycle ra[0]=7 -> 0xDEADBEEF; we, wa=0, wd=0x1234 -> ra=0 reads 0.
- Scoreboard: issue r3 -> next cycle busy for ra=3, pend_cnt=1; we wa=3 wd=0x55 -> with REGFILE_BYPASS_EN, same cycle rd=0x55, busy=0; without, busy=1 that cycle, rd=0x55 next; pend_cnt=0 after.
- Collision: r9 pending; same cycle we wa=9 wd=0xA and issue r9 -> iss_ready=1, r9 stays pending, reg=0xA, pend_cnt unchanged, err=0.
- Protocol error: r4 pending, issue r4 without writeback -> iss_ready=0, err=1 and stays 1; pend_cnt unchanged.
- Async reset mid-op: 3 registers pending, data written; pull rst_n low between edges -> pend_cnt, busy, err, rd go 0 immediately.

Source files
------------

// File: rtl/regfile_sb_if.sv
// -----------------------------------------------------------------------------
// regfile_sb_if
// Bundles the decode/writeback-side signals of the scoreboarded register file.
//   ra        : NUM_RD packed read addresses (port i at [i*ADDR_W +: ADDR_W])
//   rd        : NUM_RD packed read data      (port i at [i*DATA_W +: DATA_W])
//   busy      : per read port, register still awaiting writeback
//   we/wa/wd  : writeback port
//   iss_valid/iss_addr/iss_ready : issue port (destination register marking)
//   pend_cnt  : number of registers currently pending
//   err       : sticky protocol error (issue while not ready)
// master : pipeline side (drives addresses, writeback and issue)
// slave  : register file side
// -----------------------------------------------------------------------------
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] ra;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic [NUM_RD-1:0]        busy;
    logic                     we;
    logic [ADDR_W-1:0]        wa;
    logic [DATA_W-1:0]        wd;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     iss_ready;
    logic [ADDR_W:0]          pend_cnt;
    logic                     err;

    modport master (
        output ra, we, wa, wd, iss_valid, iss_addr,
        input  rd, busy, iss_ready, pend_cnt, err
    );

    modport slave (
        input  ra, we, wa, wd, iss_valid, iss_addr,
        output rd, busy, iss_ready, pend_cnt, err
    );
endinterface

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Register file with integrated write-pending scoreboard for the pipelined
// MIPS core. Register 0 reads as zero and is never pending.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset, clears data, pending bits, count, err
//   bus   : regfile_sb_if.slave (reads, writeback, issue, status)
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a same-cycle writeback to a read address is forwarded to rd
//                and clears busy for that port in the same cycle
//   undefined -> reads return the stored (pre-edge) value, busy follows the
//                pending bit only
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    regfile_sb_if.slave      bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    // Address 0 is not stored; bit 0 of the pending vector is held at zero so
    // any address can index it without a special case.
    logic [DATA_W-1:0] regs_r [1:DEPTH-1];
    logic [DEPTH-1:0]  pend_r;
    logic [DEPTH-1:0]  pend_nxt_s;
    logic [ADDR_W:0]   cnt_r;
    logic [ADDR_W:0]   cnt_nxt_s;
    logic              err_r;

    logic              wb_s;
    logic              iss_ready_s;
    logic              iss_acc_s;
    logic              cnt_inc_s;
    logic              cnt_dec_s;

    // Writeback qualification, issue readiness/acceptance and counter deltas.
    always_comb begin
        wb_s        = bus.we & (bus.wa != {ADDR_W{1'b0}});
        // A same-cycle writeback to the destination frees it for re-issue.
        iss_ready_s = (bus.iss_addr == {ADDR_W{1'b0}})
                    | ~pend_r[bus.iss_addr]
                    | (bus.we & (bus.wa == bus.iss_addr));
        iss_acc_s   = bus.iss_valid & iss_ready_s & (bus.iss_addr != {ADDR_W{1'b0}});
        // Re-issuing a pending register (ready only via its own writeback)
        // leaves the count unchanged, so only issues to idle registers count.
        cnt_inc_s   = iss_acc_s & ~pend_r[bus.iss_addr];
        cnt_dec_s   = wb_s & pend_r[bus.wa]
                    & ~(iss_acc_s & (bus.iss_addr == bus.wa));
    end

    // Next pending vector: accepted issue wins over a same-register writeback.
    always_comb begin
        pend_nxt_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 0) begin
                pend_nxt_s[i] = 1'b0;
            end else if (iss_acc_s && (bus.iss_addr == i[ADDR_W-1:0])) begin
                pend_nxt_s[i] = 1'b1;
            end else if (wb_s && (bus.wa == i[ADDR_W-1:0])) begin
                pend_nxt_s[i] = 1'b0;
            end else begin
                pend_nxt_s[i] = pend_r[i];
            end
        end
    end

    // Next pending count; an increment and a decrement on different registers cancel.
    always_comb begin
        if (cnt_inc_s && !cnt_dec_s) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else if (cnt_dec_s && !cnt_inc_s) begin
            cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Register data storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wb_s) begin
            regs_r[bus.wa] <= bus.wd;
        end
    end

    // Scoreboard state: pending bits, pending count and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= {DEPTH{1'b0}};
            cnt_r  <= {(ADDR_W+1){1'b0}};
            err_r  <= 1'b0;
        end else begin
            pend_r <= pend_nxt_s;
            cnt_r  <= cnt_nxt_s;
            if (bus.iss_valid && !iss_ready_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Combinational read ports.
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic [DATA_W-1:0] rd_s;
        logic              busy_s;
        logic              hit_s;

        assign ra_s = bus.ra[g*ADDR_W +: ADDR_W];

        // Per-port read mux with optional writeback forwarding.
        always_comb begin
`ifdef REGFILE_BYPASS_EN
            hit_s = wb_s & (bus.wa == ra_s);
`else
            hit_s = 1'b0;
`endif
            if (ra_s == {ADDR_W{1'b0}}) begin
                rd_s   = {DATA_W{1'b0}};
                busy_s = 1'b0;
            end else if (hit_s) begin
                rd_s   = bus.wd;
                busy_s = 1'b0;
            end else begin
                rd_s   = regs_r[ra_s];
                busy_s = pend_r[ra_s];
            end
        end

        assign bus.rd[g*DATA_W +: DATA_W] = rd_s;
        assign bus.busy[g]                = busy_s;
    end

    assign bus.iss_ready = iss_ready_s;
    assign bus.pend_cnt  = cnt_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register values, pending set, error flag.
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_pend [DEPTH];
    bit                m_err;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
        if (BYP && bus.we && bus.wa == a) return bus.wd;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
        if (a == 0) return 1'b0;
        if (BYP && bus.we && bus.wa == a) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic logic exp_ready();
        return (bus.iss_addr == 0) || !m_pend[bus.iss_addr] || (bus.we && bus.wa == bus.iss_addr);
    endfunction

    function automatic logic [ADDR_W:0] exp_cnt();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_pend[i]);
        return n[ADDR_W:0];
    endfunction

    task automatic set_in(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                          input logic iv, input logic [ADDR_W-1:0] ia);
        bus.we = we; bus.wa = wa; bus.wd = wd; bus.iss_valid = iv; bus.iss_addr = ia;
    endtask

    task automatic idle();
        set_in(1'b0, '0, '0, 1'b0, '0);
    endtask

    // Apply the current inputs to the model, then advance one clock edge.
    task automatic tick();
        bit rdy;
        rdy = exp_ready();
        if (bus.we && bus.wa != 0) begin
            m_mem[bus.wa]  = bus.wd;
            m_pend[bus.wa] = 1'b0;
        end
        if (bus.iss_valid && rdy && bus.iss_addr != 0) m_pend[bus.iss_addr] = 1'b1;
        if (bus.iss_valid && !rdy) m_err = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        bus.ra = {5'd0, 5'd5};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.rd !== 64'h0) begin errors++; $display("FAIL reset_rd got %h exp 0", bus.rd); end
        checks++; if (bus.busy !== 2'b00) begin errors++; $display("FAIL reset_busy got %b exp 00", bus.busy); end
        checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL reset_iss_ready got %b exp 1", bus.iss_ready); end
        checks++; if (bus.pend_cnt !== 6'd0) begin errors++; $display("FAIL reset_pend_cnt got %0d exp 0", bus.pend_cnt); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        bus.ra = {5'd0, 5'd0};
        set_in(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, '0);
        tick();
        idle();
        bus.ra = {5'd0, 5'd7};
        #1;
        checks++; if (bus.rd[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_port0 got %h exp deadbeef", bus.rd[31:0]); end
        bus.ra = {5'd7, 5'd0};
        #1;
        checks++; if (bus.rd !== {32'hDEADBEEF, 32'h0}) begin errors++; $display("FAIL wr_rd_port1 got %h exp deadbeef00000000", bus.rd); end
        set_in(1'b1, 5'd0, 32'h1234, 1'b0, '0);
        tick();
        idle();
        bus.ra = {5'd0, 5'd0};
        #1;
        checks++; if (bus.rd !== 64'h0) begin errors++; $display("FAIL zero_reg got %h exp 0", bus.rd); end
        checks++; if (bus.pend_cnt !== 6'd0) begin errors++; $display("FAIL zero_reg_cnt got %0d exp 0", bus.pend_cnt); end
    endtask

    task automatic test_scoreboard();
        set_in(1'b0, '0, '0, 1'b1, 5'd3);
        tick();
        idle();
        bus.ra = {5'd0, 5'd3};
        #1;
        checks++; if (bus.busy[0] !== 1'b1) begin errors++; $display("FAIL sb_busy_set got %b exp 1", bus.busy[0]); end
        checks++; if (bus.pend_cnt !== 6'd1) begin errors++; $display("FAIL sb_cnt_set got %0d exp 1", bus.pend_cnt); end
        set_in(1'b1, 5'd3, 32'h55, 1'b0, '0);
        #1;
        checks++; if (bus.rd[31:0] !== (BYP ? 32'h55 : 32'h0)) begin errors++; $display("FAIL sb_wb_rd got %h exp %h", bus.rd[31:0], BYP ? 32'h55 : 32'h0); end
        checks++; if (bus.busy[0] !== !BYP) begin errors++; $display("FAIL sb_wb_busy got %b exp %b", bus.busy[0], !BYP); end
        tick();
        idle();
        #1;
        checks++; if (bus.rd[31:0] !== 32'h55) begin errors++; $display("FAIL sb_after_rd got %h exp 55", bus.rd[31:0]); end
        checks++; if (bus.busy[0] !== 1'b0) begin errors++; $display("FAIL sb_after_busy got %b exp 0", bus.busy[0]); end
        checks++; if (bus.pend_cnt !== 6'd0) begin errors++; $display("FAIL sb_after_cnt got %0d exp 0", bus.pend_cnt); end
    endtask

    task automatic test_collision();
        set_in(1'b0, '0, '0, 1'b1, 5'd9);
        tick();
        bus.ra = {5'd0, 5'd9};
        set_in(1'b1, 5'd9, 32'hA, 1'b1, 5'd9);
        #1;
        checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL coll_ready got %b exp 1", bus.iss_ready); end
        tick();
        idle();
        #1;
        checks++; if (bus.busy[0] !== 1'b1) begin errors++; $display("FAIL coll_pending got %b exp 1", bus.busy[0]); end
        checks++; if (bus.pend_cnt !== 6'd1) begin errors++; $display("FAIL coll_cnt got %0d exp 1", bus.pend_cnt); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL coll_err got %b exp 0", bus.err); end
        checks++; if (bus.rd[31:0] !== 32'hA) begin errors++; $display("FAIL coll_data got %h exp a", bus.rd[31:0]); end
        set_in(1'b1, 5'd9, 32'hA, 1'b0, '0);
        tick();
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int hi;
            logic [ADDR_W-1:0] a0, a1;
            hi = (n < 200) ? 7 : 31;
            a0 = ADDR_W'($urandom_range(0, hi));
            a1 = ADDR_W'($urandom_range(0, hi));
            bus.ra = {a1, a0};
            set_in(1'($urandom), ADDR_W'($urandom_range(0, hi)), $urandom,
                   1'($urandom), ADDR_W'($urandom_range(0, hi)));
            if (bus.iss_valid && !exp_ready()) bus.iss_valid = 1'b0;
            #1;
            for (int p = 0; p < NUM_RD; p++) begin
                logic [ADDR_W-1:0] a;
                a = (p == 0) ? a0 : a1;
                checks++;
                if (bus.rd[p*DATA_W +: DATA_W] !== exp_rd(a)) begin
                    errors++; $display("FAIL rnd_rd%0d cyc %0d addr %0d got %h exp %h", p, n, a, bus.rd[p*DATA_W +: DATA_W], exp_rd(a));
                end
                checks++;
                if (bus.busy[p] !== exp_busy(a)) begin
                    errors++; $display("FAIL rnd_busy%0d cyc %0d addr %0d got %b exp %b", p, n, a, bus.busy[p], exp_busy(a));
                end
            end
            checks++;
            if (bus.iss_ready !== exp_ready()) begin
                errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", n, bus.iss_ready, exp_ready());
            end
            tick();
            checks++;
            if (bus.pend_cnt !== exp_cnt()) begin
                errors++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", n, bus.pend_cnt, exp_cnt());
            end
            checks++;
            if (bus.err !== m_err) begin
                errors++; $display("FAIL rnd_err cyc %0d got %b exp %b", n, bus.err, m_err);
            end
        end
        idle();
    endtask

    task automatic test_protocol_error();
        logic [ADDR_W:0] cnt_before;
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL perr_pre got %b exp 0", bus.err); end
        set_in(1'b1, 5'd4, 32'h44, 1'b1, 5'd4);
        tick();
        cnt_before = exp_cnt();
        set_in(1'b0, '0, '0, 1'b1, 5'd4);
        #1;
        checks++; if (bus.iss_ready !== 1'b0) begin errors++; $display("FAIL perr_ready got %b exp 0", bus.iss_ready); end
        tick();
        idle();
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL perr_err got %b exp 1", bus.err); end
        checks++; if (bus.pend_cnt !== cnt_before) begin errors++; $display("FAIL perr_cnt got %0d exp %0d", bus.pend_cnt, cnt_before); end
        tick();
        tick();
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL perr_sticky got %b exp 1", bus.err); end
    endtask

    task automatic test_async_reset();
        set_in(1'b1, 5'd10, 32'h10, 1'b1, 5'd10); tick();
        set_in(1'b1, 5'd11, 32'h11, 1'b1, 5'd11); tick();
        set_in(1'b1, 5'd12, 32'h12, 1'b1, 5'd12); tick();
        set_in(1'b1, 5'd13, 32'hCAFE, 1'b0, '0);  tick();
        idle();
        bus.ra = {5'd13, 5'd10};
        #1;
        checks++; if (bus.busy[0] !== 1'b1) begin errors++; $display("FAIL ar_pre_busy got %b exp 1", bus.busy[0]); end
        checks++; if (bus.rd[63:32] !== 32'hCAFE) begin errors++; $display("FAIL ar_pre_rd got %h exp cafe", bus.rd[63:32]); end
        checks++; if (bus.pend_cnt !== exp_cnt()) begin errors++; $display("FAIL ar_pre_cnt got %0d exp %0d", bus.pend_cnt, exp_cnt()); end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.pend_cnt !== 6'd0) begin errors++; $display("FAIL ar_cnt got %0d exp 0", bus.pend_cnt); end
        checks++; if (bus.busy !== 2'b00) begin errors++; $display("FAIL ar_busy got %b exp 00", bus.busy); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL ar_err got %b exp 0", bus.err); end
        checks++; if (bus.rd !== 64'h0) begin errors++; $display("FAIL ar_rd got %h exp 0", bus.rd); end
        checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL ar_ready got %b exp 1", bus.iss_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        bus.ra = '0;
        test_reset();
        test_write_read();
        test_scoreboard();
        test_collision();
        test_random();
        test_protocol_error();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
